multiexp_pnt_scl_replayer: RTL and testbench



---
 rtl/multiexp_pnt_scl_replayer.sv | 281 ++++++++++++++++++++++++++++
 tb/tb_multiexp_pnt_scl_replayer.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multiexp_pnt_scl_replayer.sv
// Point/scalar replay buffer for the bit-serial multiexp cores.
// Loads N (point, scalar) pairs once, then replays them KEY_BITS times,
// one pass per scalar bit (MSB first), tagging each beat with its key bit,
// element index, pass number and pass framing markers.
// Optional build macro: MULTIEXP_REPLAY_ZSKIP_EN suppresses zero-bit beats
// within a pass, emitting a single marker beat for an all-zero pass column.
module multiexp_pnt_scl_replayer #(
  parameter int unsigned PNT_BITS = 1536,
  parameter int unsigned KEY_BITS = 256,
  parameter int unsigned MAX_IN   = 16,
  parameter int unsigned IDX_W    = $clog2(MAX_IN),
  parameter int unsigned PASS_W   = $clog2(KEY_BITS)
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_start,
  input  logic [IDX_W:0]      i_num_in,
  input  logic                i_val,
  output logic                o_rdy,
  input  logic [PNT_BITS-1:0] i_pnt,
  input  logic [KEY_BITS-1:0] i_key,
  output logic                o_val,
  input  logic                i_rdy,
  output logic [PNT_BITS-1:0] o_pnt,
  output logic                o_key_bit,
  output logic [IDX_W-1:0]    o_idx,
  output logic [PASS_W-1:0]   o_pass,
  output logic                o_sop,
  output logic                o_eop,
  output logic                o_last,
  output logic                o_busy,
  output logic                o_err
);

  localparam int unsigned CNT_W = IDX_W + 1;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_LOAD   = 2'd1;
  localparam logic [1:0] ST_STREAM = 2'd2;

  localparam logic [PASS_W-1:0] LAST_PASS = PASS_W'(KEY_BITS - 1);
  localparam logic [CNT_W-1:0]  MAX_N     = CNT_W'(MAX_IN);

  typedef struct packed {
    logic [PNT_BITS-1:0] pnt;
    logic                key_bit;
    logic [IDX_W-1:0]    idx;
    logic [PASS_W-1:0]   pass;
    logic                sop;
    logic                eop;
    logic                last;
  } beat_t;

  logic [1:0]          state;
  logic [1:0]          state_nxt;
  logic                err_nxt;

  logic [CNT_W-1:0]    num;
  logic [IDX_W-1:0]    load_cnt;
  logic [IDX_W-1:0]    issue_idx;
  logic [PASS_W-1:0]   issue_pass;
  logic                issue_done;

  logic [PNT_BITS-1:0] pnt_mem [MAX_IN];
  logic [KEY_BITS-1:0] key_mem [MAX_IN];

  logic                start_ok_c;
  logic                load_fire_c;
  logic                load_last_c;
  logic [PASS_W-1:0]   bit_pos_c;
  logic [MAX_IN-1:0]   mask_c;
  logic [IDX_W-1:0]    emit_idx_c;
  logic                emit_bit_c;
  logic                emit_sop_c;
  logic                emit_eop_c;
  logic                emit_last_c;
  logic                pop_c;
  logic [1:0]          occ_c;
  logic                credit_c;
  logic                issue_c;
  logic                wr_hit_c;

  beat_t               s1;
  logic                s1_val;
  beat_t               head;
  beat_t               tail;
  logic                tail_val;
  logic                head_free_c;

  // Control qualifiers for start, load and the output handshake.
  assign start_ok_c  = i_start && (i_num_in != '0) && (i_num_in <= MAX_N);
  assign load_fire_c = (state == ST_LOAD) && i_val && o_rdy;
  assign load_last_c = load_fire_c && ({1'b0, load_cnt} == (num - CNT_W'(1)));
  assign pop_c       = o_val && i_rdy;
  assign bit_pos_c   = LAST_PASS - issue_pass;

  // Current pass column across all slots; the slot being written this cycle
  // is taken from the input so a first issue during the last load beat works.
  always_comb begin
    mask_c = '0;
    for (int i = 0; i < MAX_IN; i++) begin
      if (load_fire_c && (load_cnt == IDX_W'(i))) begin
        mask_c[i] = i_key[bit_pos_c] && (CNT_W'(i) < num);
      end else begin
        mask_c[i] = key_mem[i][bit_pos_c] && (CNT_W'(i) < num);
      end
    end
  end

`ifdef MULTIEXP_REPLAY_ZSKIP_EN
  logic zs_found;
  logic zs_later;

  // Pick the next set bit at or above the sweep pointer; an empty column
  // yields one idx-0 marker beat carrying key bit 0.
  always_comb begin
    zs_found   = 1'b0;
    zs_later   = 1'b0;
    emit_idx_c = '0;
    for (int i = 0; i < MAX_IN; i++) begin
      if (mask_c[i] && (IDX_W'(i) >= issue_idx)) begin
        if (!zs_found) begin
          zs_found   = 1'b1;
          emit_idx_c = IDX_W'(i);
        end else begin
          zs_later = 1'b1;
        end
      end
    end
    emit_eop_c = !zs_later;
    emit_bit_c = zs_found;
  end
`else
  // Plain sweep: every element is emitted on every pass.
  always_comb begin
    emit_idx_c = issue_idx;
    emit_eop_c = ({1'b0, issue_idx} == (num - CNT_W'(1)));
    emit_bit_c = mask_c[issue_idx];
  end
`endif

  assign emit_sop_c  = (issue_idx == '0);
  assign emit_last_c = emit_eop_c && (issue_pass == LAST_PASS);

  // Occupancy of read stage plus skid; issue only when a slot frees up.
  assign occ_c    = 2'(o_val) + 2'(tail_val) + 2'(s1_val);
  assign credit_c = ((occ_c - 2'(pop_c)) < 2'd2);
  assign issue_c  = (state == ST_LOAD)   ? load_last_c :
                    (state == ST_STREAM) ? (!issue_done && credit_c) : 1'b0;

  // Next-state and registered-output decode.
  always_comb begin
    state_nxt = state;
    err_nxt   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start_ok_c) begin
          state_nxt = ST_LOAD;
        end else if (i_start) begin
          err_nxt = 1'b1;
        end
      end
      ST_LOAD: begin
        if (load_last_c) state_nxt = ST_STREAM;
      end
      ST_STREAM: begin
        if (pop_c && o_last) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // State register with status outputs.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state  <= ST_IDLE;
      o_busy <= 1'b0;
      o_rdy  <= 1'b0;
      o_err  <= 1'b0;
    end else begin
      state  <= state_nxt;
      o_busy <= (state_nxt != ST_IDLE);
      o_rdy  <= (state_nxt == ST_LOAD);
      o_err  <= err_nxt;
    end
  end

  // Load and replay sweep counters.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      num        <= '0;
      load_cnt   <= '0;
      issue_idx  <= '0;
      issue_pass <= '0;
      issue_done <= 1'b0;
    end else begin
      if ((state == ST_IDLE) && start_ok_c) begin
        num        <= i_num_in;
        load_cnt   <= '0;
        issue_idx  <= '0;
        issue_pass <= '0;
        issue_done <= 1'b0;
      end else begin
        if (load_fire_c) load_cnt <= load_cnt + IDX_W'(1);
        if (issue_c) begin
          if (emit_eop_c) begin
            issue_idx <= '0;
            if (emit_last_c) issue_done <= 1'b1;
            else             issue_pass <= issue_pass + PASS_W'(1);
          end else begin
            issue_idx <= emit_idx_c + IDX_W'(1);
          end
        end
      end
    end
  end

  // Pair storage: point RAM and key flops, written on accepted load beats.
  always_ff @(posedge i_clk) begin
    if (load_fire_c) begin
      pnt_mem[load_cnt] <= i_pnt;
      key_mem[load_cnt] <= i_key;
    end
  end

  assign wr_hit_c = load_fire_c && (load_cnt == emit_idx_c);

  // Registered RAM read plus beat tags; write-first on a same-slot hit.
  always_ff @(posedge i_clk) begin
    if (issue_c) begin
      s1.pnt     <= wr_hit_c ? i_pnt : pnt_mem[emit_idx_c];
      s1.key_bit <= emit_bit_c;
      s1.idx     <= emit_idx_c;
      s1.pass    <= issue_pass;
      s1.sop     <= emit_sop_c;
      s1.eop     <= emit_eop_c;
      s1.last    <= emit_last_c;
    end
  end

  // Read-stage valid flag.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) s1_val <= 1'b0;
    else          s1_val <= issue_c;
  end

  assign head_free_c = !o_val || pop_c;

  // Two-entry output skid: head drives the ports, tail absorbs one in-flight read.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      head     <= '0;
      o_val    <= 1'b0;
      tail     <= '0;
      tail_val <= 1'b0;
    end else if (head_free_c) begin
      if (tail_val) begin
        head     <= tail;
        o_val    <= 1'b1;
        tail     <= s1;
        tail_val <= s1_val;
      end else begin
        if (s1_val) head <= s1;
        o_val    <= s1_val;
        tail_val <= 1'b0;
      end
    end else if (s1_val) begin
      tail     <= s1;
      tail_val <= 1'b1;
    end
  end

  assign o_pnt     = head.pnt;
  assign o_key_bit = head.key_bit;
  assign o_idx     = head.idx;
  assign o_pass    = head.pass;
  assign o_sop     = head.sop;
  assign o_eop     = head.eop;
  assign o_last    = head.last;

endmodule

// File: tb/tb_multiexp_pnt_scl_replayer.sv
// Self-checking bench for multiexp_pnt_scl_replayer (default and ZSKIP builds).
module tb_multiexp_pnt_scl_replayer;

  localparam int unsigned PNT_BITS = 1536;
  localparam int unsigned KEY_BITS = 256;
  localparam int unsigned MAX_IN   = 16;
  localparam int unsigned IDX_W    = 4;
  localparam int unsigned PASS_W   = 8;

  logic                clk;
  logic                i_rst_n;
  logic                i_start;
  logic [IDX_W:0]      i_num_in;
  logic                i_val;
  logic                o_rdy;
  logic [PNT_BITS-1:0] i_pnt;
  logic [KEY_BITS-1:0] i_key;
  logic                o_val;
  logic                i_rdy;
  logic [PNT_BITS-1:0] o_pnt;
  logic                o_key_bit;
  logic [IDX_W-1:0]    o_idx;
  logic [PASS_W-1:0]   o_pass;
  logic                o_sop;
  logic                o_eop;
  logic                o_last;
  logic                o_busy;
  logic                o_err;

  multiexp_pnt_scl_replayer #(
    .PNT_BITS(PNT_BITS), .KEY_BITS(KEY_BITS), .MAX_IN(MAX_IN),
    .IDX_W(IDX_W), .PASS_W(PASS_W)
  ) dut (
    .i_clk(clk), .i_rst_n(i_rst_n), .i_start(i_start), .i_num_in(i_num_in),
    .i_val(i_val), .o_rdy(o_rdy), .i_pnt(i_pnt), .i_key(i_key),
    .o_val(o_val), .i_rdy(i_rdy), .o_pnt(o_pnt), .o_key_bit(o_key_bit),
    .o_idx(o_idx), .o_pass(o_pass), .o_sop(o_sop), .o_eop(o_eop),
    .o_last(o_last), .o_busy(o_busy), .o_err(o_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [IDX_W-1:0]  idx;
    logic [PASS_W-1:0] pass;
    logic              kb;
    logic              sop;
    logic              eop;
    logic              last;
  } meta_t;

  typedef struct {
    logic [IDX_W:0] num;
    logic           exp_err;
    logic           exp_busy;
  } start_vec_t;

  typedef struct {
    int unsigned n;
    int unsigned rdy_pct;
    bit          gaps;
    int unsigned exp_beats;
  } run_vec_t;

  int checks = 0;
  int errors = 0;
  logic [KEY_BITS-1:0] keys [MAX_IN];
  meta_t exp_q [$];

  function automatic logic [PNT_BITS-1:0] mk_pnt(int unsigned idx, int unsigned salt);
    logic [PNT_BITS-1:0] p;
    for (int w = 0; w < int'(PNT_BITS / 32); w++) p[w*32 +: 32] = (salt << 16) ^ (idx << 8) ^ 32'(w);
    return p;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_idle_outs(input string tag);
    chk({tag, "_ctrl"}, 64'({o_rdy, o_val, o_sop, o_eop, o_last, o_busy, o_err,
                             o_key_bit, o_idx, o_pass}), 64'd0);
    chk({tag, "_pnt"}, 64'(|o_pnt), 64'd0);
  endtask

  // Reference beat list for the keys currently in keys[0..n-1].
  task automatic build_model(input int unsigned n);
    exp_q.delete();
    for (int p = 0; p < int'(KEY_BITS); p++) begin
      int b;
      int first;
      int cnt;
      b = int'(KEY_BITS) - 1 - p;
`ifdef MULTIEXP_REPLAY_ZSKIP_EN
      cnt = 0;
      for (int i = 0; i < int'(n); i++) if (keys[i][b]) cnt++;
      if (cnt == 0) begin
        exp_q.push_back(meta_t'{idx: '0, pass: PASS_W'(p), kb: 1'b0, sop: 1'b1, eop: 1'b1,
                                last: (p == int'(KEY_BITS) - 1)});
      end else begin
        first = 1;
        for (int i = 0; i < int'(n); i++) begin
          if (keys[i][b]) begin
            cnt--;
            exp_q.push_back(meta_t'{idx: IDX_W'(i), pass: PASS_W'(p), kb: 1'b1, sop: first[0],
                                    eop: (cnt == 0), last: (cnt == 0) && (p == int'(KEY_BITS) - 1)});
            first = 0;
          end
        end
      end
`else
      first = 1;
      cnt = int'(n);
      for (int i = 0; i < int'(n); i++) begin
        exp_q.push_back(meta_t'{idx: IDX_W'(i), pass: PASS_W'(p), kb: keys[i][b], sop: (i == 0),
                                eop: (i == cnt - 1), last: (i == cnt - 1) && (p == int'(KEY_BITS) - 1)});
      end
`endif
    end
  endtask

  // Starts a run; entered and left just after a falling edge.
  task automatic do_start(input int unsigned n);
    i_start = 1'b1;
    i_num_in = (IDX_W+1)'(n);
    @(posedge clk); @(negedge clk);
    i_start = 1'b0;
    chk("start_busy", 64'(o_busy), 64'd1);
    chk("start_rdy", 64'(o_rdy), 64'd1);
  endtask

  task automatic do_load(input int unsigned n, input int unsigned salt, input bit gaps);
    for (int i = 0; i < int'(n); i++) begin
      while (gaps && ($urandom_range(0, 2) == 0)) begin
        i_val = 1'b0;
        @(posedge clk); @(negedge clk);
      end
      i_val = 1'b1;
      i_pnt = mk_pnt(i, salt);
      i_key = keys[i];
      chk("load_rdy", 64'(o_rdy), 64'd1);
      @(posedge clk); @(negedge clk);
    end
    i_val = 1'b0;
  endtask

  // Drains the replay, comparing every accepted beat with the model.
  task automatic do_stream(input int unsigned salt, input int unsigned rdy_pct,
                           input int abort_beats, output int got);
    int cyc;
    int first_cyc;
    int nlast;
    int limit;
    bit stalled;
    bit rdy;
    meta_t act_m;
    meta_t prev_m;
    logic [PNT_BITS-1:0] prev_p;
    cyc = 0; first_cyc = -1; nlast = 0; got = 0; stalled = 1'b0;
    prev_m = '0; prev_p = '0;
    limit = exp_q.size() * 4 + 50;
    while ((got < exp_q.size()) && (got < abort_beats)) begin
      act_m = meta_t'{idx: o_idx, pass: o_pass, kb: o_key_bit, sop: o_sop, eop: o_eop, last: o_last};
      if (stalled) begin
        chk("stall_val", 64'(o_val), 64'd1);
        chk("stall_meta", 64'(act_m), 64'(prev_m));
        chk("stall_pnt", o_pnt[63:0], prev_p[63:0]);
      end
      if (o_val && (first_cyc < 0)) begin
        first_cyc = cyc;
        chk("first_val_latency", 64'(first_cyc), 64'd1);
      end
      rdy = ($urandom_range(1, 100) <= rdy_pct);
      i_rdy = rdy;
      if (o_val && rdy) begin
        chk($sformatf("beat%0d_meta", got), 64'(act_m), 64'(exp_q[got]));
        chk($sformatf("beat%0d_pnt", got), 64'(o_pnt == mk_pnt(o_idx, salt)), 64'd1);
        if (o_last) nlast++;
        got++;
      end
      stalled = o_val && !rdy;
      prev_m = act_m;
      prev_p = o_pnt;
      @(posedge clk); @(negedge clk);
      cyc++;
      if (cyc > limit) begin
        chk("stream_timeout", 64'(got), 64'(exp_q.size()));
        break;
      end
    end
    i_rdy = 1'b0;
    if (got >= exp_q.size()) begin
      chk("single_last", 64'(nlast), 64'd1);
      chk("done_busy", 64'(o_busy), 64'd0);
      chk("done_val", 64'(o_val), 64'd0);
    end
  endtask

  task automatic rand_keys(input int unsigned n);
    for (int i = 0; i < int'(n); i++)
      for (int w = 0; w < int'(KEY_BITS / 32); w++) keys[i][w*32 +: 32] = $urandom;
  endtask

  start_vec_t start_tbl [3];
  run_vec_t   run_tbl [4];

  initial begin
    int got;
    start_tbl[0] = '{num: 5'd0,  exp_err: 1'b1, exp_busy: 1'b0};
    start_tbl[1] = '{num: 5'd17, exp_err: 1'b1, exp_busy: 1'b0};
    start_tbl[2] = '{num: 5'd31, exp_err: 1'b1, exp_busy: 1'b0};
    run_tbl[0] = '{n: 4,  rdy_pct: 100, gaps: 1'b0, exp_beats: 1024};
    run_tbl[1] = '{n: 3,  rdy_pct: 50,  gaps: 1'b1, exp_beats: 768};
    run_tbl[2] = '{n: 1,  rdy_pct: 100, gaps: 1'b0, exp_beats: 256};
    run_tbl[3] = '{n: 16, rdy_pct: 100, gaps: 1'b0, exp_beats: 4096};

    i_rst_n = 1'b0; i_start = 1'b0; i_num_in = '0; i_val = 1'b0;
    i_pnt = '0; i_key = '0; i_rdy = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_idle_outs("reset");
    i_rst_n = 1'b1;
    @(posedge clk); @(negedge clk);

    // Bad element counts: one-cycle error pulse, never busy.
    foreach (start_tbl[v]) begin
      i_start = 1'b1;
      i_num_in = start_tbl[v].num;
      @(posedge clk); @(negedge clk);
      i_start = 1'b0;
      chk($sformatf("bad%0d_err", start_tbl[v].num), 64'(o_err), 64'(start_tbl[v].exp_err));
      chk($sformatf("bad%0d_busy", start_tbl[v].num), 64'(o_busy), 64'(start_tbl[v].exp_busy));
      @(posedge clk); @(negedge clk);
      chk($sformatf("bad%0d_err_pulse", start_tbl[v].num), 64'(o_err), 64'd0);
    end

    // Full replay runs.
    foreach (run_tbl[r]) begin
      rand_keys(run_tbl[r].n);
      build_model(run_tbl[r].n);
      do_start(run_tbl[r].n);
      do_load(run_tbl[r].n, r + 1, run_tbl[r].gaps);
      do_stream(r + 1, run_tbl[r].rdy_pct, 1 << 30, got);
`ifdef MULTIEXP_REPLAY_ZSKIP_EN
      chk($sformatf("run%0d_beats", r), 64'(got), 64'(exp_q.size()));
`else
      chk($sformatf("run%0d_beats", r), 64'(got), 64'(run_tbl[r].exp_beats));
`endif
    end

    // i_start ignored while busy: extra pulse during load must not restart.
    rand_keys(2);
    build_model(2);
    do_start(2);
    i_start = 1'b1; i_num_in = 5'd5;
    @(posedge clk); @(negedge clk);
    i_start = 1'b0;
    do_load(2, 9, 1'b0);
    do_stream(9, 100, 1 << 30, got);
    chk("busy_start_ignored_beats", 64'(got), 64'(exp_q.size()));

    // Reset in the middle of pass 7, then a fresh N=2 run.
    rand_keys(4);
    build_model(4);
    do_start(4);
    do_load(4, 11, 1'b0);
    do_stream(11, 100, 7 * 4 + 2, got);
    chk("pre_reset_busy", 64'(o_busy), 64'd1);
    i_rst_n = 1'b0;
    #1;
    chk_idle_outs("midrun_reset");
    @(negedge clk);
    i_rst_n = 1'b1;
    @(posedge clk); @(negedge clk);
    rand_keys(2);
    build_model(2);
    do_start(2);
    do_load(2, 12, 1'b0);
    do_stream(12, 100, 1 << 30, got);
`ifndef MULTIEXP_REPLAY_ZSKIP_EN
    chk("post_reset_beats", 64'(got), 64'd512);
`else
    chk("post_reset_beats", 64'(got), 64'(exp_q.size()));

    // Sparse keys: top bit only and bottom bit only.
    keys[0] = '0; keys[0][KEY_BITS-1] = 1'b1;
    keys[1] = '0; keys[1][0] = 1'b1;
    build_model(2);
    do_start(2);
    do_load(2, 13, 1'b0);
    do_stream(13, 100, 1 << 30, got);
    chk("zskip_beats", 64'(got), 64'(KEY_BITS));
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
